// File: rtl/ram_frame_writer_pkg.sv
// Shared definitions for the frame RAM writer: op codes, grid geometry and FSM states.
package ram_frame_writer_pkg;

    localparam int GRID_DIM  = 16;
    localparam int GRID_BITS = 4;
    localparam int CNT_BITS  = 2 * GRID_BITS;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_FILL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        RD,
        RDW,
        WR,
        FILL
    } state_e;

    // True when the fill counter addresses the final cell of the raster.
    function automatic logic is_last_cell(input logic [CNT_BITS-1:0] cnt);
        return cnt == CNT_BITS'(GRID_DIM * GRID_DIM - 1);
    endfunction

endpackage

// File: rtl/ram_frame_writer_if.sv
// Command handshake plus frame RAM port of the writer, bundled as one bus.
interface ram_frame_writer_if;
    import ram_frame_writer_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [GRID_BITS-1:0] cmd_x;
    logic [GRID_BITS-1:0] cmd_y;
    logic                 cmd_val;

    logic [GRID_BITS-1:0] ram_x;
    logic [GRID_BITS-1:0] ram_y;
    logic                 ram_we;
    logic                 ram_wdata;
    logic                 ram_rdata;

    // The master issues commands and owns the RAM; the slave is the writer itself.
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_val, ram_rdata,
        input  cmd_ready, ram_x, ram_y, ram_we, ram_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_val, ram_rdata,
        output cmd_ready, ram_x, ram_y, ram_we, ram_wdata
    );

endinterface

// File: rtl/ram_frame_writer.sv
// Turns set/clear/toggle/fill pixel commands into write (or read-modify-write)
// cycles on the 16x16 frame RAM, optionally confined to vertical blanking.
module ram_frame_writer
    import ram_frame_writer_pkg::*;
#(
    parameter bit SYNC_TO_VBLANK = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_frame_writer_if.slave      bus,
    input  logic                   vblank,
    output logic                   busy,
    output logic                   done
);

    state_e               state;
    logic [1:0]           op_q;
    logic [GRID_BITS-1:0] x_q;
    logic [GRID_BITS-1:0] y_q;
    logic                 val_q;
    logic [CNT_BITS-1:0]  cnt;
    logic [CNT_BITS-1:0]  next_cnt;
    logic                 vb_ok;

    assign vb_ok         = !SYNC_TO_VBLANK || vblank;
    assign busy          = (state != IDLE);
    assign bus.cmd_ready = (state == IDLE);

    // The fill counter only advances past a cell once that cell has really been written.
    always_comb begin
        next_cnt = cnt;
        if (bus.ram_we) begin
            next_cnt = cnt + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= OP_SET;
            x_q           <= '0;
            y_q           <= '0;
            val_q         <= 1'b0;
            cnt           <= '0;
            bus.ram_x     <= '0;
            bus.ram_y     <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q  <= bus.cmd_op;
                        x_q   <= bus.cmd_x;
                        y_q   <= bus.cmd_y;
                        val_q <= bus.cmd_val;
                        state <= WAIT_VB;
                    end
                end

                WAIT_VB: begin
                    if (vb_ok) begin
                        case (op_q)
                            OP_TOGGLE: begin
                                bus.ram_x <= x_q;
                                bus.ram_y <= y_q;
                                state     <= RD;
                            end
                            OP_FILL: begin
                                cnt           <= '0;
                                bus.ram_x     <= '0;
                                bus.ram_y     <= '0;
                                bus.ram_wdata <= val_q;
                                bus.ram_we    <= 1'b1;
                                state         <= FILL;
                            end
                            default: begin
                                bus.ram_x     <= x_q;
                                bus.ram_y     <= y_q;
                                bus.ram_wdata <= (op_q == OP_SET);
                                bus.ram_we    <= 1'b1;
                                state         <= WR;
                            end
                        endcase
                    end
                end

                RD: begin
                    state <= RDW;
                end

                // Read data for the latched address arrives in this cycle.
                RDW: begin
                    bus.ram_wdata <= ~bus.ram_rdata;
                    bus.ram_we    <= 1'b1;
                    state         <= WR;
                end

                WR: begin
                    bus.ram_we <= 1'b0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end

                FILL: begin
                    if (bus.ram_we && is_last_cell(cnt)) begin
                        bus.ram_we <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt        <= next_cnt;
                        bus.ram_x  <= next_cnt[GRID_BITS-1:0];
                        bus.ram_y  <= next_cnt[CNT_BITS-1:GRID_BITS];
                        bus.ram_we <= vb_ok;
                    end
                end

                default: begin
                    bus.ram_we <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_frame_writer.sv
// Directed plus randomized bench for ram_frame_writer against a frame-image and write-log model.
module tb_ram_frame_writer;
    import ram_frame_writer_pkg::*;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       d;
        int         c;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic vblank;
    logic busy;
    logic done;

    logic [255:0] env_mem = '0;
    logic [255:0] model_mem;
    int           cyc = 0;
    wr_t          wr_q[$];

    int n_vec = 0;
    int n_err = 0;
    int last_done = 0;
    int last_hs = 0;

    ram_frame_writer_if bus();

    ram_frame_writer #(.SYNC_TO_VBLANK(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .vblank (vblank),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Behaves like ram_16x16: synchronous read-first port; every committed write is logged.
    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) begin
            env_mem[{bus.ram_y, bus.ram_x}] <= bus.ram_wdata;
            wr_q.push_back('{bus.ram_x, bus.ram_y, bus.ram_wdata, cyc});
        end
        bus.ram_rdata <= env_mem[{bus.ram_y, bus.ram_x}];
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one command and checks latency, write log and RAM image.
    // exp_extra is the number of vblank-low cycles that fall in WAIT_VB or FILL.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                                 input logic v, input int stall_at, input int stall_len,
                                 input int exp_extra, input int reset_at, input bit hold_next);
        int   hs, k, done_k, base, bad, waited, n_exp, seen_done;
        logic d;
        wr_t  exp_q[$];

        base = (op == OP_FILL) ? 258 : (op == OP_TOGGLE) ? 5 : 3;
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_val   = v;
        bus.cmd_valid = 1'b1;
        vblank        = 1'b1;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_ready", 32'(bus.cmd_ready), 32'd1);
        hs      = cyc;
        last_hs = hs;
        wr_q.delete();

        @(negedge clk);
        if (hold_next) begin
            bus.cmd_op = OP_CLR;
            bus.cmd_x  = 4'd0;
            bus.cmd_y  = 4'd0;
        end else begin
            bus.cmd_valid = 1'b0;
        end

        done_k = -1;
        bad    = 0;
        for (k = cyc - hs; k < base + exp_extra + 40; k = cyc - hs) begin
            vblank = !(k >= stall_at && k < stall_at + stall_len);
            if (k == reset_at) break;
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        vblank = 1'b1;

        if (reset_at > 0) begin
            rst_n = 1'b0;
            #1;
            checkOutput("reset_outputs",
                        32'({bus.ram_we, done, busy, bus.cmd_ready, bus.ram_x, bus.ram_y, bus.ram_wdata}),
                        32'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0}));
            n_exp = reset_at - 2;
            for (int i = 0; i < n_exp; i++) model_mem[i] = v;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            seen_done = 0;
            repeat (4) begin
                @(negedge clk);
                if (done === 1'b1) seen_done++;
            end
            checkOutput("reset_no_done", 32'(seen_done), 32'd0);
            checkOutput("reset_idle_ready", 32'({busy, bus.cmd_ready}), 32'b01);
            checkOutput("reset_busy_ready", 32'(bad), 32'd0);
            checkOutput("reset_write_count", 32'(wr_q.size()), 32'(n_exp));
            checkOutput("reset_ram_image", 32'($countones(env_mem ^ model_mem)), 32'd0);
            last_done = cyc;
            return;
        end

        checkOutput("done_cycle", 32'(done_k), 32'(base + exp_extra));
        checkOutput("busy_ready", 32'(bad), 32'd0);

        if (op == OP_FILL) begin
            for (int i = 0; i < 256; i++) exp_q.push_back('{4'(i % 16), 4'(i / 16), v, 0});
            model_mem = {256{v}};
        end else begin
            d = (op == OP_SET) ? 1'b1 : (op == OP_CLR) ? 1'b0 : ~model_mem[{y, x}];
            exp_q.push_back('{x, y, d, 0});
            model_mem[{y, x}] = d;
        end

        checkOutput("write_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checkOutput("write_addr_data", 32'({wr_q[i].x, wr_q[i].y, wr_q[i].d}),
                        32'({exp_q[i].x, exp_q[i].y, exp_q[i].d}));
        end
        if (wr_q.size() > 0) begin
            checkOutput("first_write_cycle", 32'(wr_q[0].c - hs),
                        32'((op == OP_FILL) ? 2 : base + exp_extra - 1));
            checkOutput("last_write_cycle", 32'(wr_q[$].c - hs), 32'(base + exp_extra - 1));
        end
        checkOutput("ram_image", 32'($countones(env_mem ^ model_mem)), 32'd0);
        last_done = cyc;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int prev_done, len;
        logic [1:0] rop;

        rst_n         = 1'b0;
        vblank        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_SET;
        bus.cmd_x     = 4'd0;
        bus.cmd_y     = 4'd0;
        bus.cmd_val   = 1'b0;
        model_mem     = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_state",
                    32'({bus.ram_we, done, busy, bus.cmd_ready, bus.ram_x, bus.ram_y, bus.ram_wdata}),
                    32'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0}));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", 32'({busy, bus.cmd_ready, done}), 32'b010);

        $display("[TB] basic SET, toggle pair, vblank behaviour");
        applyStimulus(OP_SET, 4'd3, 4'd5, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(OP_SET, 4'd7, 4'd9, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(OP_TOGGLE, 4'd7, 4'd9, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(OP_TOGGLE, 4'd7, 4'd9, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(OP_TOGGLE, 4'd2, 4'd14, 1'b0, 2, 3, 0, 0, 1'b0);
        applyStimulus(OP_SET, 4'd1, 4'd2, 1'b0, 1, 20, 20, 0, 1'b0);

        $display("[TB] back-to-back commands");
        applyStimulus(OP_SET, 4'd4, 4'd4, 1'b0, 0, 0, 0, 0, 1'b0);
        prev_done = last_done;
        applyStimulus(OP_CLR, 4'd4, 4'd4, 1'b0, 0, 0, 0, 0, 1'b0);
        checkOutput("b2b_accept_cycle", 32'(last_hs), 32'(prev_done));

        applyStimulus(OP_FILL, 4'd0, 4'd0, 1'b1, 102, 10, 10, 0, 1'b1);
        prev_done = last_done;
        applyStimulus(OP_CLR, 4'd0, 4'd0, 1'b0, 0, 0, 0, 0, 1'b0);
        checkOutput("held_accept_cycle", 32'(last_hs), 32'(prev_done));

        $display("[TB] randomized pixel commands");
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 2));
            len = int'($urandom_range(0, 3));
            applyStimulus(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0,
                          1, len, len, 0, 1'b0);
        end

        $display("[TB] fill clear, reset mid-fill, recovery");
        applyStimulus(OP_FILL, 4'd0, 4'd0, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(OP_FILL, 4'd0, 4'd0, 1'b1, 0, 0, 0, 52, 1'b0);
        applyStimulus(OP_SET, 4'd10, 4'd11, 1'b0, 0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_frame_writer.md
# ram_frame_writer

Command-driven writer for the 16x16 one-bit frame RAM (`ram_16x16`), the write-side counterpart of the VGA RAM display path. It accepts pixel commands over a valid/ready handshake: set, clear, toggle, or fill-all. It converts each command into RAM write cycles, or read-modify-write cycles for toggle. With vblank sync enabled, writes occur only during vertical blanking, so the display scan never sees a partially updated frame. It sits beside the display reader at top level; the top-level address mux gives the RAM port to this block whenever `busy` is high.

## Interface
- `SYNC_TO_VBLANK`, default 1: 1 = RAM accesses only while `vblank`=1; 0 = ignore `vblank`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block idle and able to accept a command.
- `cmd_op`  in  2  operation: 00 SET, 01 CLR, 10 TOGGLE, 11 FILL.
- `cmd_x`  in  4  pixel column (SET/CLR/TOGGLE).
- `cmd_y`  in  4  pixel row (SET/CLR/TOGGLE).
- `cmd_val`  in  1  fill value (FILL only).
- `vblank`  in  1  vertical blanking indicator from the VGA timing generator.
- `ram_x`  out  4  RAM column address.
- `ram_y`  out  4  RAM row address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  1  RAM write data.
- `ram_rdata`  in  1  RAM read data; synchronous, valid the cycle after the address.
- `busy`  out  1  command in progress; also the top-level RAM address mux select.
- `done`  out  1  one-cycle pulse after the final write of a command.

## Operation
- States: IDLE, WAIT_VB, RD, RDW, WR, FILL.
- IDLE:
  - `cmd_ready`=1 and `busy`=0.
  - A handshake (`cmd_valid`&`cmd_ready`) latches op, x, y, val, then goes to WAIT_VB.
- WAIT_VB: holds while `SYNC_TO_VBLANK`=1 and `vblank`=0. Otherwise:
  - SET/CLR go to WR.
  - TOGGLE goes to RD.
  - FILL goes to FILL with the 8-bit counter = 0.
- RD:
  - `ram_x/ram_y` = latched address, `ram_we`=0.
  - Next state is RDW.
- RDW: capture `ram_rdata` at the end of the cycle, then go to WR.
- WR:
  - Exactly one cycle with `ram_we`=1.
  - `ram_wdata` = 1 for SET, 0 for CLR, ~captured for TOGGLE.
  - Returns to IDLE; `done`=1 in the next cycle.
- FILL:
  - `ram_x`=cnt[3:0], `ram_y`=cnt[7:4], `ram_wdata`=val, `ram_we`=1; cnt increments each cycle.
  - If `SYNC_TO_VBLANK`=1 and `vblank`=0: `ram_we`=0 and cnt holds; resumes when `vblank` returns.
  - After the cnt=255 write, go to IDLE and pulse `done`.
- SET/CLR/TOGGLE are atomic once past WAIT_VB; a `vblank` fall during RD/RDW/WR does not stall them.
- `busy` = state != IDLE.
- A `cmd_valid` while busy is not accepted; the master holds it until ready.
- In the `done` cycle, `cmd_ready`=1, so a back-to-back command is accepted in that cycle.
- Counter width is 8 bits. Address fields are 4 bits, so there are no out-of-range coordinates.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `ram_we`=0, `ram_x`=0, `ram_y`=0, `ram_wdata`=0, cnt=0.
- RAM outputs are registered.
- Handshake in cycle N; `vblank` high throughout:
  - SET/CLR: `ram_we`=1 in N+2, `done`=1 in N+3.
  - TOGGLE: RD in N+2, RDW in N+3, `ram_we`=1 in N+4, `done`=1 in N+5.
  - FILL: `ram_we`=1 in N+2..N+257, `done`=1 in N+258.
- Each cycle with `vblank`=0 spent in WAIT_VB or FILL adds exactly one cycle of latency.
- Reset asserted mid-command:
  - `ram_we` drops asynchronously; no further writes are issued.
  - RAM keeps partial contents; no `done` pulse.

## Structure
- Shared package/header holds:
  - the op-code constants (OP_SET, OP_CLR, OP_TOGGLE, OP_FILL);
  - GRID_DIM=16 and GRID_BITS=4;
  - the state encoding.
- No sub-module: a single FSM plus an inline fill counter.
- `ram_16x16` and the address mux stay at top level, not inside this block.

## Test plan
- SET (x=3, y=5) with `vblank`=1 → single `ram_we` pulse at N+2 with `ram_x`=3, `ram_y`=5, `ram_wdata`=1; `done` at N+3.
- TOGGLE (7,9) on a pixel preloaded to 1 → RAM read at (7,9), write of 0 at N+4; repeating the toggle writes 1.
- FILL `cmd_val`=1 with `vblank` dropped for 10 cycles at cnt=100 → 256 writes in raster order with no skipped or repeated addresses; `done` at N+268.
- SET issued while `vblank`=0 for 20 cycles → no `ram_we` until `vblank` rises; `busy`=1 throughout.
- Back-to-back commands:
  - CLR accepted in the `done` cycle of a prior SET → writes in order, no cycle lost.
  - `cmd_valid` held during FILL → not accepted until FILL completes.
- `rst_n` low at fill cnt=50 → `ram_we`=0 immediately, outputs at reset values; after release, `cmd_ready`=1 and a new SET completes normally.
